// File: rtl/mul_div_if.sv
// Request/response bundle between the execute-stage control and the RV32M multiply/divide unit.
interface mul_div_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rd;
    logic                  div_by_zero;

    modport master (
        output start, op, rs1, rs2,
        input  busy, done, rd, div_by_zero
    );

    modport slave (
        input  start, op, rs1, rs2,
        output busy, done, rd, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// fixed latency of DATA_WIDTH+3 cycles from acceptance to the done pulse.
module mul_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_div_if.slave   bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    state_e          state, state_nxt;
    op_e             op_q;
    logic [W-1:0]    a_q, b_q, opnd_q, rd_q;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_rem_q, dbz_q;
    logic            busy_w, done_w, accept;

    logic            is_div, b_zero, a_signed, b_signed, sa, sb;
    logic [W-1:0]    mag_a, mag_b, quot, rem, result;
    logic [W:0]      mul_sum, rem_sh, diff;
    logic [2*W-1:0]  acc_step, prod_fix;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_w    = 1'b0;
        done_w    = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = PREP;
            PREP: begin
                busy_w    = 1'b1;
                state_nxt = CALC;
            end
            CALC: begin
                busy_w = 1'b1;
                if (cnt == CW'(W - 1)) state_nxt = FIX;
            end
            FIX: begin
                busy_w    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_w    = 1'b1;
                state_nxt = bus.start ? PREP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand preparation: magnitudes and result-sign flags from the latched operands
    always_comb begin
        is_div   = op_q[2];
        b_zero   = (b_q == '0);
        a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
        b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        sa       = a_signed && a_q[W-1];
        sb       = b_signed && b_q[W-1];
        mag_a    = sa ? -a_q : a_q;
        mag_b    = sb ? -b_q : b_q;
    end

    // One iteration: acc holds {hi, lo}; multiply shifts right, divide shifts left
    always_comb begin
        mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, opnd_q & {W{acc[0]}}};
        rem_sh  = {acc[2*W-1:W], acc[W-1]};
        diff    = rem_sh - {1'b0, opnd_q};
        if (is_div) begin
            if (diff[W]) acc_step = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
            else         acc_step = {diff[W-1:0],   acc[W-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[W-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quot     = acc[W-1:0];
        rem      = acc[2*W-1:W];
        case (op_q)
            OP_MUL:                       result = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:              result = dbz_q ? '1  : (neg_q ? -quot : quot);
            OP_REM, OP_REMU:              result = dbz_q ? a_q : (neg_rem_q ? -rem : rem);
            default:                      result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q            <= OP_MUL;
            a_q             <= '0;
            b_q             <= '0;
            opnd_q          <= '0;
            acc             <= '0;
            cnt             <= '0;
            neg_q           <= 1'b0;
            neg_rem_q       <= 1'b0;
            dbz_q           <= 1'b0;
            rd_q            <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_q            <= op_e'(bus.op);
                a_q             <= bus.rs1;
                b_q             <= bus.rs2;
                bus.div_by_zero <= 1'b0;
            end
            case (state)
                PREP: begin
                    opnd_q    <= is_div ? mag_b : mag_a;
                    acc       <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
                    neg_q     <= sa ^ sb;
                    neg_rem_q <= sa;
                    dbz_q     <= is_div && b_zero;
                    cnt       <= '0;
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    rd_q            <= result;
                    bus.div_by_zero <= dbz_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_w;
    assign bus.done = done_w;
    assign bus.rd   = rd_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, handshake/reset sequences
// and randomized operations against a plain-arithmetic RV32M reference.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mul_div_if #(.DATA_WIDTH(32)) bus ();

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_rd;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: RV32M results straight from integer arithmetic
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        logic        dz;
        sa = a;
        sb = b;
        dz = 1'b0;
        r  = '0;
        case (op)
            3'b000: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            3'b001: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            3'b010: begin p = longint'(sa) * longint'({32'h0, b}); r = p[63:32]; end
            3'b011: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'b100: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = sa / sb;
            end
            3'b101: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
                else r = a / b;
            end
            3'b110: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = sa % sb;
            end
            default: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else r = a % b;
            end
        endcase
        return {dz, r};
    endfunction

    // Issue one op from an idle unit; inputs are scrambled right after acceptance
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic dz,
                          output int lat, output int busy_cyc, output int done_cyc);
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.rs1   = $urandom;
        bus.rs2   = $urandom;
        lat       = 1;
        busy_cyc  = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busy_cyc++;
        end
        r        = bus.rd;
        dz       = bus.div_by_zero;
        done_cyc = bus.done ? 1 : 0;
        @(posedge clk); #1;
        if (bus.done) done_cyc++;
    endtask

    initial begin
        logic [31:0] r, a, b;
        logic [32:0] m;
        logic [2:0]  op;
        logic        dz;
        int          lat, bc, dc, k, ndone;

        vecs[0]  = '{3'b000, 32'd7,          32'd6,          32'd42,         1'b0};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[8]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[9]  = '{3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[12] = '{3'b111, 32'd9,          32'd0,          32'd9,          1'b1};

        bus.start = 1'b0;
        bus.op    = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 0);
        check("reset_done", 64'(bus.done), 0);
        check("reset_rd",   64'(bus.rd), 0);
        check("reset_dbz",  64'(bus.div_by_zero), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, dz, lat, bc, dc);
            check($sformatf("vec%0d_rd", i),      64'(r),   64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_dbz", i),     64'(dz),  64'(vecs[i].exp_dbz));
            check($sformatf("vec%0d_latency", i), 64'(lat), 35);
            check($sformatf("vec%0d_busy", i),    64'(bc),  34);
            check($sformatf("vec%0d_done", i),    64'(dc),  1);
            if (i == 0) begin
                repeat (3) @(posedge clk);
                #1;
                check("idle_rd_held", 64'(bus.rd), 42);
                check("idle_busy",    64'(bus.busy), 0);
            end
        end

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = -$urandom_range(1, 1000);
                default: ;
            endcase
            m = model(op, a, b);
            run_op(op, a, b, r, dz, lat, bc, dc);
            check($sformatf("rand%0d_op%0d_rd", n, op), 64'(r),  64'(m[31:0]));
            check($sformatf("rand%0d_dbz", n),          64'(dz), 64'(m[32]));
        end

        // Inputs changed and start re-pulsed while busy: ignored
        bus.op = 3'b000; bus.rs1 = 32'd1234; bus.rs2 = 32'd5678; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 1; ndone = 0; lat = 0; r = '0;
        while (k < 80) begin
            if (k == 10) begin
                bus.op = 3'b100; bus.rs1 = 32'd99; bus.rs2 = 32'd0; bus.start = 1'b1;
            end
            @(posedge clk); #1;
            k++;
            if (k == 11) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (lat == 0) begin lat = k; r = bus.rd; end
            end
        end
        check("busy_start_ignored_rd",    64'(r),     64'd7006652);
        check("busy_start_ignored_lat",   64'(lat),   35);
        check("busy_start_single_done",   64'(ndone), 1);

        // start held through DONE: back-to-back acceptance with no idle cycle
        bus.op = 3'b011; bus.rs1 = 32'hFFFF_FFFF; bus.rs2 = 32'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.op = 3'b101; bus.rs1 = 32'd9; bus.rs2 = 32'd0;
        k = 1;
        while (!bus.done && k < 100) begin @(posedge clk); #1; k++; end
        check("b2b_first_lat", 64'(k), 35);
        check("b2b_first_rd",  64'(bus.rd), 64'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_no_idle_busy", 64'(bus.busy), 1);
        k = 1;
        while (!bus.done && k < 100) begin @(posedge clk); #1; k++; end
        check("b2b_second_lat", 64'(k), 35);
        check("b2b_second_rd",  64'(bus.rd), 64'hFFFF_FFFF);
        check("b2b_second_dbz", 64'(bus.div_by_zero), 1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a divide
        bus.op = 3'b100; bus.rs1 = 32'd1000; bus.rs2 = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(bus.busy), 0);
        check("async_rst_done", 64'(bus.done), 0);
        check("async_rst_rd",   64'(bus.rd), 0);
        check("async_rst_dbz",  64'(bus.div_by_zero), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ndone++;
        end
        check("post_rst_no_activity", 64'(ndone), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
